// File: rtl/decodificador_botao_if.sv
// Button decoder signal bundle: raw button level in, debounced level and press strobes out.
// master = button/stimulus side, slave = decoder side.
interface decodificador_botao_if;
  logic push_button;
  logic pressionado;
  logic pulso_curto;
  logic pulso_longo;
  logic ocupado;

  modport master (
    output push_button,
    input  pressionado,
    input  pulso_curto,
    input  pulso_longo,
    input  ocupado
  );

  modport slave (
    input  push_button,
    output pressionado,
    output pulso_curto,
    output pulso_longo,
    output ocupado
  );
endinterface

// File: rtl/decodificador_botao.sv
// Debounces a push button and classifies each press as short or long, one strobe per press.
// Define BOTAO_SYNC_EN for a two-flop input synchronizer; otherwise the input is registered once.
module decodificador_botao #(
  parameter int DEBOUNCE_P        = 300,
  parameter int SWITCH_MODE_MIN_T = 5300
) (
  input  logic                        clk,
  input  logic                        rst,
  decodificador_botao_if.slave        bus,
  output logic [1:0]                  estado_dbg
);

  localparam int CW = $clog2(SWITCH_MODE_MIN_T + 1);
  localparam logic [CW-1:0] DP_C = CW'(DEBOUNCE_P);
  localparam logic [CW-1:0] SW_C = CW'(SWITCH_MODE_MIN_T);

  localparam logic [1:0] ARMANDO  = 2'd0;
  localparam logic [1:0] OCIOSO   = 2'd1;
  localparam logic [1:0] CONTANDO = 2'd2;
  localparam logic [1:0] SEGURADO = 2'd3;

  if (DEBOUNCE_P < 1 || SWITCH_MODE_MIN_T <= DEBOUNCE_P) begin : g_bad_params
    $error("decodificador_botao: need DEBOUNCE_P >= 1 and SWITCH_MODE_MIN_T > DEBOUNCE_P");
  end

`ifdef BOTAO_SYNC_EN
  localparam int SYNC_N = 2;
`else
  localparam int SYNC_N = 1;
`endif

  logic [SYNC_N-1:0] sync_q, sync_d;
  logic [SYNC_N-1:0] vld_q, vld_d;
  logic              btn_s, btn_vld;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressionado_q, pressionado_d;
  logic          pulso_curto_q, pulso_curto_d;
  logic          pulso_longo_q, pulso_longo_d;
  logic          ocupado_q, ocupado_d;

  // vld tracks how far the reset-cleared synchronizer has refilled, so ARMANDO
  // never mistakes the flushed zeros for a release of a button held through reset.
  always_comb begin
`ifdef BOTAO_SYNC_EN
    sync_d = {sync_q[0], bus.push_button};
    vld_d  = {vld_q[0], 1'b1};
`else
    sync_d = bus.push_button;
    vld_d  = 1'b1;
`endif
  end

  assign btn_s   = sync_q[SYNC_N-1];
  assign btn_vld = vld_q[SYNC_N-1];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pulso_curto_d = 1'b0;
    pulso_longo_d = 1'b0;
    case (state_q)
      ARMANDO: begin
        if (btn_vld && !btn_s) begin
          state_d = OCIOSO;
          cnt_d   = '0;
        end
      end
      OCIOSO: begin
        if (btn_s) begin
          state_d = CONTANDO;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      CONTANDO: begin
        if (btn_s) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == SW_C - CW'(1)) begin
            state_d       = SEGURADO;
            pulso_longo_d = 1'b1;
          end
        end else begin
          state_d       = OCIOSO;
          cnt_d         = '0;
          pulso_curto_d = (cnt_q >= DP_C) && (cnt_q < SW_C);
        end
      end
      SEGURADO: begin
        if (btn_s) begin
          cnt_d = SW_C;
        end else begin
          state_d = OCIOSO;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARMANDO;
        cnt_d   = '0;
      end
    endcase
    pressionado_d = ((state_d == CONTANDO) || (state_d == SEGURADO)) && (cnt_d >= DP_C);
    ocupado_d     = (state_d != OCIOSO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      vld_q         <= '0;
      state_q       <= ARMANDO;
      cnt_q         <= '0;
      pressionado_q <= 1'b0;
      pulso_curto_q <= 1'b0;
      pulso_longo_q <= 1'b0;
      ocupado_q     <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      vld_q         <= vld_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pressionado_q <= pressionado_d;
      pulso_curto_q <= pulso_curto_d;
      pulso_longo_q <= pulso_longo_d;
      ocupado_q     <= ocupado_d;
    end
  end

  assign bus.pressionado = pressionado_q;
  assign bus.pulso_curto = pulso_curto_q;
  assign bus.pulso_longo = pulso_longo_q;
  assign bus.ocupado     = ocupado_q;
  assign estado_dbg      = state_q;

endmodule

// File: tb/tb_decodificador_botao.sv
// Bench for decodificador_botao: directed press lengths, reset mid-press, bounce and random
// presses, every cycle compared against a run-length model of the button behaviour.
module tb_decodificador_botao;

  localparam int DP = 300;
  localparam int SW = 5300;
`ifdef BOTAO_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] estado_dbg;

  decodificador_botao_if bus ();

  decodificador_botao #(
    .DEBOUNCE_P        (DP),
    .SWITCH_MODE_MIN_T (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .estado_dbg (estado_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: press = run of high samples; vector {pressionado, curto, longo, ocupado}
  logic [3:0] exp_q[$];
  logic       hist[$];
  int         run = 0;
  bit         blocked = 1'b0;
  int         exp_c_tot = 0;
  int         exp_l_tot = 0;

  task automatic model_step();
    logic b;
    bit   v;
    logic e_p, e_c, e_l, e_o;
    e_p = 1'b0; e_c = 1'b0; e_l = 1'b0; e_o = 1'b0;
    if (rst) begin
      hist.delete();
      run     = 0;
      blocked = 1'b1;
    end else begin
      v = (hist.size() >= LAT);
      b = v ? hist[0] : 1'b0;
      hist.push_back(bus.push_button);
      if (hist.size() > LAT) void'(hist.pop_front());
      if (!v) begin
        e_o = 1'b1;
      end else if (b) begin
        e_o = 1'b1;
        if (!blocked) begin
          run++;
          e_p = (run >= DP);
          e_l = (run == SW);
        end
      end else begin
        e_c     = !blocked && (run >= DP) && (run < SW);
        blocked = 1'b0;
        run     = 0;
      end
    end
    if (e_c) exp_c_tot++;
    if (e_l) exp_l_tot++;
    exp_q.push_back({e_p, e_c, e_l, e_o});
  endtask

  bit model_on = 1'b0;
  initial forever begin
    @(posedge clk);
    if (rst) model_on = 1'b1;
    if (model_on) model_step();
  end

  // scoreboard / monitor
  int obs_c = 0;
  int obs_l = 0;
  int obs_p = 0;

  initial forever begin
    logic [3:0] e;
    @(negedge clk);
    if (bus.pulso_curto === 1'b1) obs_c++;
    if (bus.pulso_longo === 1'b1) obs_l++;
    if (bus.pressionado === 1'b1) obs_p++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("pressionado", 32'(bus.pressionado), 32'(e[3]));
      check_eq("pulso_curto", 32'(bus.pulso_curto), 32'(e[2]));
      check_eq("pulso_longo", 32'(bus.pulso_longo), 32'(e[1]));
      check_eq("ocupado", 32'(bus.ocupado), 32'(e[0]));
      check_eq("strobe_excl", 32'(bus.pulso_curto & bus.pulso_longo), 32'(0));
    end
  end

  // drivers
  task automatic drive(input logic v, input int n);
    bus.push_button = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input string tag, input int n, input int ec, input int el, input int ep);
    int c0, l0, p0;
    c0 = obs_c; l0 = obs_l; p0 = obs_p;
    drive(1'b1, n);
    drive(1'b0, 20);
    check_eq({tag, "_curto_n"}, 32'(obs_c - c0), 32'(ec));
    check_eq({tag, "_longo_n"}, 32'(obs_l - l0), 32'(el));
    if (ep >= 0) check_eq({tag, "_press_n"}, 32'(obs_p - p0), 32'(ep));
  endtask

  initial begin
    int c0, l0, longs;
    rst = 1'b1;
    bus.push_button = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_pressionado", 32'(bus.pressionado), 32'(0));
    check_eq("reset_ocupado", 32'(bus.ocupado), 32'(0));
    check_eq("reset_state", 32'(estado_dbg), 32'(0));
    rst = 1'b0;
    drive(1'b0, 5);

    press("p299", 299, 0, 0, 0);
    press("p300", 300, 1, 0, 1);
    press("p5299", 5299, 1, 0, 5299 - DP + 1);
    press("p5830", 5830, 0, 1, 5830 - DP + 1);
    check_eq("idle_ocupado", 32'(bus.ocupado), 32'(0));

    // button held across a reset pulse, then released and pressed again
    c0 = obs_c; l0 = obs_l;
    drive(1'b1, 1000);
    rst = 1'b1;
    repeat (400) @(negedge clk);
    check_eq("rst_mid_ocupado", 32'(bus.ocupado), 32'(0));
    check_eq("rst_mid_pressionado", 32'(bus.pressionado), 32'(0));
    rst = 1'b0;
    drive(1'b1, 6000);
    check_eq("held_after_rst_curto_n", 32'(obs_c - c0), 32'(0));
    check_eq("held_after_rst_longo_n", 32'(obs_l - l0), 32'(0));
    drive(1'b0, 20);
    press("after_rst", 400, 1, 0, 400 - DP + 1);

    // bounce then a valid press
    c0 = obs_c; l0 = obs_l;
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end
    press("bounce", 350, 1, 0, 350 - DP + 1);
    check_eq("bounce_total_curto", 32'(obs_c - c0), 32'(1));

    // random presses and gaps
    longs = 0;
    for (int i = 0; i < 24; i++) begin
      int len;
      if (longs < 3 && $urandom_range(0, 7) == 0) begin
        len = $urandom_range(SW - 10, SW + 10);
        longs++;
      end else begin
        len = $urandom_range(1, 700);
      end
      drive(1'b1, len);
      drive(1'b0, $urandom_range(1, 15));
    end
    drive(1'b0, 20);
    check_eq("total_curto", 32'(obs_c), 32'(exp_c_tot));
    check_eq("total_longo", 32'(obs_l), 32'(exp_l_tot));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
